// File: rtl/ysyx_22050550_csr_wb.sv
// Machine-mode CSR execute/writeback unit.
// Accepts one CSR/trap request, computes new CSR values and the PC redirect.
module ysyx_22050550_csr_wb (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [11:0] csr_addr,
  input  logic [63:0] src,
  input  logic [63:0] pc,
  input  logic [63:0] mepc,
  input  logic [63:0] mcause,
  input  logic [63:0] mtvec,
  input  logic [63:0] mstatus,
  input  logic [63:0] mie,
  input  logic [63:0] mip,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] rd_data,
  output logic        illegal,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [63:0] wbmepc,
  output logic [63:0] wbmcause,
  output logic [63:0] wbmtvec,
  output logic [63:0] wbmstatus,
  output logic [63:0] wbmie,
  output logic [63:0] wbmip,
  output logic [7:0]  wbcsren
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  localparam logic [2:0] OP_RW    = 3'b000;
  localparam logic [2:0] OP_RS    = 3'b001;
  localparam logic [2:0] OP_RC    = 3'b010;
  localparam logic [2:0] OP_ECALL = 3'b011;
  localparam logic [2:0] OP_MRET  = 3'b100;
  localparam logic [2:0] OP_IRQ   = 3'b101;

  state_e state_q, state_d;

  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [63:0] src_q, pc_q;

  logic [63:0] rd_q, rd_d;
  logic        ill_q, ill_d;
  logic        rv_q, rv_d;
  logic [63:0] rpc_q, rpc_d;
  logic [63:0] epc_q, epc_d, cause_q, cause_d, tvec_q, tvec_d;
  logic [63:0] stat_q, stat_d, ie_q, ie_d, ip_q, ip_d;
  logic [7:0]  mask_q, mask_d;

  logic [5:0]  sel;
  logic [63:0] old, nv, st;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel = 6'b0;
    unique case (addr_q)
      12'h341: sel = 6'b000001;
      12'h342: sel = 6'b000010;
      12'h305: sel = 6'b000100;
      12'h300: sel = 6'b001000;
      12'h304: sel = 6'b010000;
      12'h344: sel = 6'b100000;
      default: sel = 6'b0;
    endcase
  end

  always_comb begin
    old = '0;
    unique case (1'b1)
      sel[0]:  old = mepc;
      sel[1]:  old = mcause;
      sel[2]:  old = mtvec;
      sel[3]:  old = mstatus;
      sel[4]:  old = mie;
      sel[5]:  old = mip;
      default: old = '0;
    endcase
  end

  always_comb begin
    rd_d    = '0;
    ill_d   = 1'b0;
    rv_d    = 1'b0;
    rpc_d   = '0;
    mask_d  = '0;
    epc_d   = mepc;
    cause_d = mcause;
    tvec_d  = mtvec;
    stat_d  = mstatus;
    ie_d    = mie;
    ip_d    = mip;
    nv      = '0;
    st      = mstatus;
    unique case (op_q)
      OP_RW, OP_RS, OP_RC: begin
        if (sel == 6'b0) begin
          ill_d = 1'b1;
        end else begin
          rd_d = old;
          unique case (op_q)
            OP_RW:   nv = src_q;
            OP_RS:   nv = old | src_q;
            default: nv = old & ~src_q;
          endcase
          if (op_q == OP_RW || src_q != '0)
            mask_d = {2'b00, sel};
          if (sel[0]) epc_d   = nv;
          if (sel[1]) cause_d = nv;
          if (sel[2]) tvec_d  = nv;
          if (sel[3]) stat_d  = nv;
          if (sel[4]) ie_d    = nv;
          if (sel[5]) ip_d    = nv;
        end
      end
      OP_ECALL, OP_IRQ: begin
        st[7]     = mstatus[3];
        st[3]     = 1'b0;
        st[12:11] = 2'b11;
        stat_d    = st;
        epc_d     = pc_q;
        cause_d   = (op_q == OP_IRQ) ? 64'h8000_0000_0000_0007 : 64'd11;
        mask_d    = 8'h0B;
        rv_d      = 1'b1;
        rpc_d     = mtvec & ~64'h3;
      end
      OP_MRET: begin
        st[3]     = mstatus[7];
        st[7]     = 1'b1;
        st[12:11] = 2'b11;
        stat_d    = st;
        mask_d    = 8'h08;
        rv_d      = 1'b1;
        rpc_d     = mepc;
      end
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      tvec_q  <= '0;
      stat_q  <= '0;
      ie_q    <= '0;
      ip_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && in_valid) begin
        op_q   <= op;
        addr_q <= csr_addr;
        src_q  <= src;
        pc_q   <= pc;
      end
      if (state_q == S_EXEC) begin
        rd_q    <= rd_d;
        ill_q   <= ill_d;
        rv_q    <= rv_d;
        rpc_q   <= rpc_d;
        epc_q   <= epc_d;
        cause_q <= cause_d;
        tvec_q  <= tvec_d;
        stat_q  <= stat_d;
        ie_q    <= ie_d;
        ip_q    <= ip_d;
        mask_q  <= mask_d;
      end
    end
  end

  assign in_ready       = (state_q == S_IDLE) & reset;
  assign out_valid      = (state_q == S_RESP);
  assign rd_data        = rd_q;
  assign illegal        = ill_q;
  assign redirect_valid = rv_q & out_valid;
  assign redirect_pc    = rpc_q;
  assign wbmepc         = epc_q;
  assign wbmcause       = cause_q;
  assign wbmtvec        = tvec_q;
  assign wbmstatus      = stat_q;
  assign wbmie          = ie_q;
  assign wbmip          = ip_q;
  // Enables only fire on the handshake cycle so the regfile writes once.
  assign wbcsren        = mask_q & {8{out_valid & out_ready}};

endmodule

// File: tb/tb_ysyx_22050550_csr_wb.sv
// Randomized bench for ysyx_22050550_csr_wb.
// Directed trap/CSR cases, stall and reset abort, then random requests.
module tb_ysyx_22050550_csr_wb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [11:0] csr_addr = '0;
  logic [63:0] src = '0;
  logic [63:0] pc = '0;
  logic [63:0] csr [6];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] rd_data, redirect_pc;
  logic        illegal, redirect_valid;
  logic [63:0] wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
  logic [7:0]  wbcsren;

  int n_run = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [63:0]      rd;
    logic             ill;
    logic             rv;
    logic [63:0]      rpc;
    logic [5:0][63:0] wb;
    logic [7:0]       mask;
  } exp_t;

  always #5 clock = ~clock;

  ysyx_22050550_csr_wb dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .csr_addr(csr_addr), .src(src), .pc(pc),
    .mepc(csr[0]), .mcause(csr[1]), .mtvec(csr[2]),
    .mstatus(csr[3]), .mie(csr[4]), .mip(csr[5]),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_data(rd_data), .illegal(illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec),
    .wbmstatus(wbmstatus), .wbmie(wbmie), .wbmip(wbmip),
    .wbcsren(wbcsren)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Reference: CSR array indexed mepc,mcause,mtvec,mstatus,mie,mip.
  function automatic exp_t model();
    exp_t e;
    int idx;
    logic [63:0] old, ms;
    e = '0;
    for (int i = 0; i < 6; i++) e.wb[i] = csr[i];
    case (csr_addr)
      12'h341: idx = 0;
      12'h342: idx = 1;
      12'h305: idx = 2;
      12'h300: idx = 3;
      12'h304: idx = 4;
      12'h344: idx = 5;
      default: idx = -1;
    endcase
    if (op <= 3'd2) begin
      if (idx < 0) begin
        e.ill = 1'b1;
      end else begin
        old = csr[idx];
        e.rd = old;
        if (op == 3'd0) e.wb[idx] = src;
        else if (op == 3'd1) e.wb[idx] = old | src;
        else e.wb[idx] = old & ~src;
        if (op == 3'd0 || src != 0) e.mask = 8'(1 << idx);
      end
    end else if (op == 3'd3 || op == 3'd5) begin
      ms = csr[3];
      ms[7] = csr[3][3];
      ms[3] = 1'b0;
      ms[12:11] = 2'b11;
      e.wb[0] = pc;
      e.wb[1] = (op == 3'd3) ? 64'd11 : 64'h8000_0000_0000_0007;
      e.wb[3] = ms;
      e.mask = 8'h0B;
      e.rv = 1'b1;
      e.rpc = csr[2] - (csr[2] % 4);
    end else if (op == 3'd4) begin
      ms = csr[3];
      ms[3] = csr[3][7];
      ms[7] = 1'b1;
      ms[12:11] = 2'b11;
      e.wb[3] = ms;
      e.mask = 8'h08;
      e.rv = 1'b1;
      e.rpc = csr[0];
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic check_outs(input exp_t e, input string w);
    chk({w, " rd_data"}, rd_data, e.rd);
    chk({w, " illegal"}, 64'(illegal), 64'(e.ill));
    chk({w, " redirect_valid"}, 64'(redirect_valid), 64'(e.rv));
    chk({w, " redirect_pc"}, redirect_pc, e.rpc);
    chk({w, " wbmepc"}, wbmepc, e.wb[0]);
    chk({w, " wbmcause"}, wbmcause, e.wb[1]);
    chk({w, " wbmtvec"}, wbmtvec, e.wb[2]);
    chk({w, " wbmstatus"}, wbmstatus, e.wb[3]);
    chk({w, " wbmie"}, wbmie, e.wb[4]);
    chk({w, " wbmip"}, wbmip, e.wb[5]);
  endtask

  task automatic do_req(input int hold);
    exp_t e;
    @(negedge clock);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk("in_ready idle", 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk("exec out_valid", 64'(out_valid), 64'd0);
    chk("exec in_ready", 64'(in_ready), 64'd0);
    e = model();
    @(negedge clock);
    for (int i = 0; i < 6; i++) csr[i] = r64();
    op = 3'($urandom);
    csr_addr = 12'($urandom);
    src = r64();
    pc = r64();
    chk("resp out_valid", 64'(out_valid), 64'd1);
    chk("resp in_ready", 64'(in_ready), 64'd0);
    chk("resp wbcsren", 64'(wbcsren), 64'd0);
    check_outs(e, "resp");
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("stall out_valid", 64'(out_valid), 64'd1);
      chk("stall wbcsren", 64'(wbcsren), 64'd0);
      check_outs(e, "stall");
    end
    out_ready = 1'b1;
    #1;
    chk("xfer wbcsren", 64'(wbcsren), 64'(e.mask));
    @(negedge clock);
    out_ready = 1'b0;
    chk("post out_valid", 64'(out_valid), 64'd0);
    chk("post wbcsren", 64'(wbcsren), 64'd0);
    chk("post redirect_valid", 64'(redirect_valid), 64'd0);
    chk("post in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic set_req(input logic [2:0] o, input logic [11:0] a,
                         input logic [63:0] s, input logic [63:0] p);
    op = o;
    csr_addr = a;
    src = s;
    pc = p;
  endtask

  initial begin
    logic [11:0] amap [6];
    amap = '{12'h341, 12'h342, 12'h305, 12'h300, 12'h304, 12'h344};
    for (int i = 0; i < 6; i++) csr[i] = '0;
    repeat (3) @(negedge clock);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst wbcsren", 64'(wbcsren), 64'd0);
    chk("rst rd_data", rd_data, 64'd0);
    chk("rst redirect_valid", 64'(redirect_valid), 64'd0);
    reset = 1'b1;
    #1;
    chk("rel in_ready", 64'(in_ready), 64'd1);

    set_req(3'b000, 12'h305, 64'h8000_0100, 64'h0);
    do_req(0);
    for (int i = 0; i < 6; i++) csr[i] = '0;
    csr[2] = 64'h8000_0101;
    csr[3] = 64'hA_0000_1808;
    set_req(3'b011, 12'h0, 64'h0, 64'h8000_0040);
    do_req(1);
    for (int i = 0; i < 6; i++) csr[i] = '0;
    csr[0] = 64'h8000_0044;
    csr[3] = 64'hA_0000_1880;
    set_req(3'b100, 12'h0, 64'h0, 64'h0);
    do_req(5);
    csr[3] = 64'hA_0000_1808;
    set_req(3'b001, 12'h300, 64'h0, 64'h0);
    do_req(0);
    set_req(3'b000, 12'h7C0, 64'h1234, 64'h0);
    do_req(0);
    set_req(3'b101, 12'h0, 64'h0, 64'h8000_2000);
    do_req(2);
    set_req(3'b111, 12'h300, 64'h5, 64'h0);
    do_req(0);

    // Abort a request while in EXEC.
    set_req(3'b000, 12'h341, 64'hDEAD, 64'h0);
    @(negedge clock);
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd0);
    chk("abort wbcsren", 64'(wbcsren), 64'd0);
    chk("abort wbmepc", wbmepc, 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("abort rel in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("abort idle out_valid", 64'(out_valid), 64'd0);
      chk("abort idle wbcsren", 64'(wbcsren), 64'd0);
    end
    out_ready = 1'b0;

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 6; i++) csr[i] = r64();
      set_req(3'($urandom_range(0, 7)),
              ($urandom_range(0, 3) != 0) ? amap[$urandom_range(0, 5)]
                                          : 12'($urandom),
              ($urandom_range(0, 3) == 0) ? 64'h0 : r64(),
              r64());
      do_req($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_csr_wb.md
YSYX_22050550_CSR_WB -- requirements
Module: ysyx_22050550_csr_wb

Interface
REQ-001 SHALL have ports, each: name  direction  width  meaning.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  request handshake.
REQ-005 op  in  3  request opcode: 000 CSRRW, 001 CSRRS, 010 CSRRC, 011 ECALL, 100 MRET, 101 timer IRQ, others illegal.
REQ-006 csr_addr  in  12  target CSR address; used by ops 000-010 only.
REQ-007 src  in  64  rs1 value or zero-extended zimm.
REQ-008 pc  in  64  PC of the request.
REQ-009 mepc, mcause, mtvec, mstatus, mie, mip  in  64 each  current CSR values from the register file.
REQ-010 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-011 rd_data  out  64  old CSR value for rd.
REQ-012 illegal  out  1  request faulted; no CSR written.
REQ-013 redirect_valid / redirect_pc  out / out  1 / 64  PC redirect for ECALL, MRET and IRQ.
REQ-014 wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip  out  64 each  new CSR values.
REQ-015 wbcsren  out  8  write enables: bit0 mepc, bit1 mcause, bit2 mtvec, bit3 mstatus, bit4 mie, bit5 mip, bits 7:6 always 0.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE with reset high; a transfer (in_valid & in_ready) captures op, csr_addr, src and pc, and moves to EXEC.
REQ-018 EXEC SHALL last exactly one cycle, sample the six CSR inputs, compute all results into registers, then enter RESP.
REQ-019 out_valid SHALL be 1 throughout RESP; outputs stay stable until out_ready; transfer (out_valid & out_ready) returns to IDLE.
REQ-020 Minimum latency SHALL be 2 cycles from input transfer edge to out_valid; throughput at most one request per 3 cycles.
REQ-021 wbcsren SHALL equal the computed mask ANDed with (out_valid & out_ready): a one-cycle pulse, only on the output transfer cycle.
REQ-022 CSR address map SHALL be: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x344 mip.
REQ-023 For ops 000-010, rd_data SHALL be the old CSR value.
REQ-024 New CSR value SHALL be: CSRRW src; CSRRS old|src; CSRRC old&~src.
REQ-025 CSRRS/CSRRC with src==0 SHALL set no wbcsren bit; CSRRW SHALL always set its bit.
REQ-026 Unmapped csr_addr or undefined op SHALL give illegal=1, rd_data=0, mask=0, redirect_valid=0.
REQ-027 ECALL SHALL produce:
 - mepc=pc, mcause=11.
 - mstatus: bit7 (MPIE)=old bit3, bit3 (MIE)=0, bits12:11 (MPP)=2'b11, other bits unchanged.
 - mask=8'h0B; redirect_pc={mtvec[63:2],2'b00}.
REQ-028 Timer IRQ SHALL match ECALL except mcause=64'h8000_0000_0000_0007.
REQ-029 MRET SHALL produce:
 - mstatus: bit3=old bit7, bit7=1, bits12:11=2'b11.
 - mask=8'h08; redirect_pc=mepc.
REQ-030 redirect_valid SHALL be 1 in RESP only for ECALL, IRQ and MRET; rd_data=0 for these ops.
REQ-031 wb* outputs for unmasked CSRs SHALL equal the sampled current value.

Reset
REQ-032 reset low at a clock edge SHALL force IDLE and clear all registered outputs to 0 (wbcsren=0, out_valid=0).
REQ-033 An in-flight request SHALL be discarded by reset; no wbcsren pulse is issued for it.
REQ-034 in_ready SHALL be 0 while reset is low and 1 on the first cycle after release.

Verification
REQ-035 CSRRW 0x305, src=0x8000_0100, mtvec=0 -> out_valid 2 cycles after accept; rd_data=0; wbmtvec=0x8000_0100; wbcsren=0x04 for one cycle.
REQ-036 ECALL, pc=0x8000_0040, mtvec=0x8000_0101, mstatus=0xA0000_1808 -> wbmepc=0x8000_0040, wbmcause=11, wbmstatus=0xA0000_1880, wbcsren=0x0B, redirect_pc=0x8000_0100.
REQ-037 MRET, mepc=0x8000_0044, mstatus=0xA0000_1880 -> wbmstatus=0xA0000_1888, wbcsren=0x08, redirect_pc=0x8000_0044.
REQ-038 CSRRS 0x300 src=0 -> rd_data=mstatus, wbcsren=0; CSRRW 0x7C0 -> illegal=1, wbcsren=0.
REQ-039 Hold out_ready=0 for 5 cycles in RESP -> outputs stable, in_ready=0, wbcsren=0; pulse appears only on the out_ready cycle.
REQ-040 Assert reset in EXEC -> next cycle IDLE, out_valid=0, no wbcsren pulse ever for that request.
